// File: rtl/prog_loader_pkg.sv
// Shared types and sizing helpers for the switch-bank program loader.
package prog_loader_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    function automatic int chunks(input int word_w, input int sw_w);
        return (word_w / sw_w < 1) ? 1 : word_w / sw_w;
    endfunction

    function automatic int idx_w(input int n_chunks);
        return $clog2(n_chunks) + 1;
    endfunction

endpackage

// File: rtl/prog_loader_edge_rise.sv
// One-bit rising-edge detector: registers the previous level, flags 0->1.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= lvl;
    end

    assign rise = lvl & ~prev;

endmodule

// File: rtl/prog_loader.sv
// Assembles RAM words from switch-bank chunks (MSB chunk first) and emits
// one-cycle write strobes with an auto-incrementing, non-wrapping pointer.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int SW_W       = 8,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [SW_W-1:0]                               switch,
    input  logic                                          enter,
    input  logic                                          abort,
    input  logic                                          set_addr,
    output logic [ADDR_W-1:0]                             addr_wr,
    output logic [WORD_W-1:0]                             data_wr,
    output logic                                          wr_en,
    output logic [idx_w(chunks(WORD_W, SW_W))-1:0]        chunk_idx,
    output logic                                          full,
    output logic [ADDR_W:0]                               word_cnt
);

    localparam int CHUNKS = chunks(WORD_W, SW_W);
    localparam int IDX_W  = idx_w(CHUNKS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHUNKS - 1);
    localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    logic enter_rise, abort_rise, set_rise;

    edge_rise u_enter (.clk(clk), .rst(rst), .lvl(enter),    .rise(enter_rise));
    edge_rise u_abort (.clk(clk), .rst(rst), .lvl(abort),    .rise(abort_rise));
    edge_rise u_set   (.clk(clk), .rst(rst), .lvl(set_addr), .rise(set_rise));

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [WORD_W-1:0]   data_d;
    logic                wr_d;
    logic [IDX_W-1:0]    idx_d;
    logic                full_d;
    logic [ADDR_W:0]     cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_wr;
        data_d  = data_wr;
        wr_d    = 1'b0;
        idx_d   = chunk_idx;
        full_d  = full;
        cnt_d   = word_cnt;

        // Pointer advance trails the strobe by one cycle; a set_addr edge
        // in that same cycle overrides it below.
        if (wr_en) begin
            if (addr_wr == '1) begin
                state_d = FULL;
                full_d  = 1'b1;
            end else begin
                addr_d = addr_wr + 1'b1;
            end
        end

        if (abort_rise) begin
            idx_d  = '0;
            data_d = '0;
        end else if (set_rise) begin
            addr_d  = ADDR_W'(switch);
            idx_d   = '0;
            data_d  = '0;
            state_d = COLLECT;
            full_d  = 1'b0;
        end else if (enter_rise && state_q == COLLECT) begin
            data_d[WORD_W-1-int'(chunk_idx)*SW_W -: SW_W] = switch;
            if (chunk_idx == LAST_IDX) begin
                idx_d = '0;
                wr_d  = 1'b1;
                if (word_cnt != CNT_MAX) cnt_d = word_cnt + 1'b1;
            end else begin
                idx_d = chunk_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            addr_wr   <= ADDR_W'(START_ADDR);
            data_wr   <= '0;
            wr_en     <= 1'b0;
            chunk_idx <= '0;
            full      <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            addr_wr   <= addr_d;
            data_wr   <= data_d;
            wr_en     <= wr_d;
            chunk_idx <= idx_d;
            full      <= full_d;
            word_cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: stimulus queues expected {addr,data} writes, a monitor
// pops them on every wr_en strobe; direct checks cover status outputs.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  switch;
    logic        enter, abort, set_addr;
    logic [3:0]  addr_wr;
    logic [15:0] data_wr;
    logic        wr_en;
    logic [1:0]  chunk_idx;
    logic        full;
    logic [4:0]  word_cnt;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    logic        wr_prev = 1'b0;

    prog_loader #(
        .SW_W(8), .WORD_W(16), .ADDR_W(4), .START_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .switch(switch), .enter(enter), .abort(abort),
        .set_addr(set_addr), .addr_wr(addr_wr), .data_wr(data_wr), .wr_en(wr_en),
        .chunk_idx(chunk_idx), .full(full), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe must match the head of the expectation queue.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                checks++;
                if (wr_prev) begin
                    errors++;
                    $display("FAIL wr_en_back_to_back: wr_en high two cycles running");
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, none expected", addr_wr, data_wr);
                end else begin
                    e = exp_q.pop_front();
                    if ({addr_wr, data_wr} !== e) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 addr_wr, data_wr, e[19:16], e[15:0]);
                    end
                end
            end
            wr_prev = wr_en;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input logic [7:0] v);
        switch = v;
        enter  = 1'b1;
        tick();
        enter  = 1'b0;
        tick();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic do_set(input logic [7:0] v);
        switch   = v;
        set_addr = 1'b1;
        tick();
        set_addr = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; switch = '0; enter = 1'b0; abort = 1'b0; set_addr = 1'b0;
        do_reset();

        check("reset_addr",  32'(addr_wr),   32'd0);
        check("reset_data",  32'(data_wr),   32'h0);
        check("reset_idx",   32'(chunk_idx), 32'd0);
        check("reset_full",  32'(full),      32'd0);
        check("reset_cnt",   32'(word_cnt),  32'd0);
        check("reset_wr_en", 32'(wr_en),     32'd0);

        // First word 0xABCD to address 0
        press(8'hAB);
        check("first_chunk_idx",  32'(chunk_idx), 32'd1);
        check("first_chunk_data", 32'(data_wr),   32'hAB00);
        exp_q.push_back({4'd0, 16'hABCD});
        press(8'hCD);
        check("word1_ptr", 32'(addr_wr),   32'd1);
        check("word1_cnt", 32'(word_cnt),  32'd1);
        check("word1_idx", 32'(chunk_idx), 32'd0);

        // Held enter: one event only
        switch = 8'h12;
        enter  = 1'b1;
        repeat (10) tick();
        enter  = 1'b0;
        tick();
        check("held_idx",  32'(chunk_idx), 32'd1);
        check("held_data", 32'(data_wr),   32'h12CD);
        do_abort();
        check("abort_idx",  32'(chunk_idx), 32'd0);
        check("abort_data", 32'(data_wr),   32'h0);
        check("abort_ptr",  32'(addr_wr),   32'd1);
        check("abort_cnt",  32'(word_cnt),  32'd1);

        // Abort discards a partial word
        do_reset();
        press(8'h11);
        do_abort();
        press(8'h22);
        exp_q.push_back({4'd0, 16'h2233});
        press(8'h33);
        check("abort_word_ptr", 32'(addr_wr),  32'd1);
        check("abort_word_cnt", 32'(word_cnt), 32'd1);

        // Fill to the top address, then FULL
        do_set(8'h0E);
        check("set_ptr", 32'(addr_wr), 32'd14);
        press(8'h01);
        exp_q.push_back({4'd14, 16'h0102});
        press(8'h02);
        check("ptr_15", 32'(addr_wr), 32'd15);
        check("not_full_yet", 32'(full), 32'd0);
        press(8'h03);
        exp_q.push_back({4'd15, 16'h0304});
        press(8'h04);
        check("full_set",    32'(full),     32'd1);
        check("full_no_wrap", 32'(addr_wr), 32'd15);
        check("full_cnt",    32'(word_cnt), 32'd3);
        press(8'h55);
        press(8'h66);
        check("full_enter_ignored_idx", 32'(chunk_idx), 32'd0);
        check("full_enter_ignored_cnt", 32'(word_cnt),  32'd3);
        do_set(8'h03);
        check("full_cleared", 32'(full),    32'd0);
        check("reset_ptr_3",  32'(addr_wr), 32'd3);
        press(8'h05);
        exp_q.push_back({4'd3, 16'h0506});
        press(8'h06);
        check("ptr_4", 32'(addr_wr),  32'd4);
        check("cnt_4", 32'(word_cnt), 32'd4);

        // abort + set_addr + enter together mid-word: abort wins
        press(8'h77);
        switch = 8'h09; abort = 1'b1; set_addr = 1'b1; enter = 1'b1;
        tick();
        abort = 1'b0; set_addr = 1'b0; enter = 1'b0;
        tick();
        check("prio_idx",  32'(chunk_idx), 32'd0);
        check("prio_data", 32'(data_wr),   32'h0);
        check("prio_ptr",  32'(addr_wr),   32'd4);
        check("prio_cnt",  32'(word_cnt),  32'd4);

        // Reset coincident with the final enter edge suppresses the write
        press(8'h88);
        switch = 8'h99; enter = 1'b1; rst = 1'b1;
        tick();
        enter = 1'b0; rst = 1'b0;
        check("rst_final_wr_en", 32'(wr_en), 32'd0);
        tick();
        check("rst_final_addr", 32'(addr_wr),   32'd0);
        check("rst_final_cnt",  32'(word_cnt),  32'd0);
        check("rst_final_idx",  32'(chunk_idx), 32'd0);
        tick();

        check("writes_all_seen", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter SW_W, default 8, switch bank width in bits.
REQ-002 SHALL have parameter WORD_W, default 16, RAM word width; WORD_W SHALL be an integer multiple of SW_W (CHUNKS = WORD_W/SW_W, at least 1).
REQ-003 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-004 SHALL have parameter START_ADDR, default 0, first write address after reset.
REQ-005 SHALL have port clk, input, 1, clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port switch, input, SW_W, data or address chunk from the switches.
REQ-008 SHALL have port enter, input, 1, level button; each rising edge commits one chunk.
REQ-009 SHALL have port abort, input, 1, level button; a rising edge discards the partial word.
REQ-010 SHALL have port set_addr, input, 1, level button; a rising edge loads the write pointer from switch[ADDR_W-1:0], zero-extended if SW_W < ADDR_W.
REQ-011 SHALL have port addr_wr, output, ADDR_W, RAM write address.
REQ-012 SHALL have port data_wr, output, WORD_W, RAM write data.
REQ-013 SHALL have port wr_en, output, 1, one-cycle RAM write strobe.
REQ-014 SHALL have port chunk_idx, output, clog2(CHUNKS)+1, number of chunks collected for the current word.
REQ-015 SHALL have port full, output, 1, high when the top address has been written.
REQ-016 SHALL have port word_cnt, output, ADDR_W+1, words written since reset, saturating.

Function
REQ-017 Each button SHALL be rising-edge detected: pressed when the current level is 1 and the registered previous level is 0; a held button produces one event only.
REQ-018 States: COLLECT and FULL; chunk_idx counts from 0 to CHUNKS-1 within COLLECT.
REQ-019 Priority per cycle, highest first: rst > abort > set_addr > enter; lower-priority events in the same cycle SHALL be ignored, not deferred.
REQ-020 enter in COLLECT SHALL write switch into data_wr bits [WORD_W-1-k*SW_W -: SW_W] for k = chunk_idx (MSB chunk first), then increment chunk_idx.
REQ-021 On the enter edge for chunk CHUNKS-1:
- wr_en = 1 for exactly the next cycle, with addr_wr = the current pointer and data_wr = the full word;
- chunk_idx resets to 0;
- word_cnt increments, saturating at 2^ADDR_W.
REQ-022 After a write, the pointer SHALL increment in the cycle after wr_en; addr_wr SHALL always show the pointer, and data_wr SHALL hold its last value until the next chunk.
REQ-023 If the written address equals 2^ADDR_W-1, the block SHALL enter FULL with full = 1 and SHALL NOT wrap the pointer.
REQ-024 In FULL, enter SHALL be ignored; set_addr SHALL load the pointer, clear full and return to COLLECT.
REQ-025 abort SHALL clear chunk_idx and data_wr to 0 and leave the pointer, word_cnt and full unchanged.
REQ-026 set_addr mid-word SHALL also discard the partial word (chunk_idx = 0, data_wr = 0).
REQ-027 With CHUNKS = 1, every enter edge SHALL produce a write.
REQ-028 wr_en SHALL never be high in two consecutive cycles.

Reset
REQ-029 rst SHALL set:
- state = COLLECT, pointer = START_ADDR, chunk_idx = 0;
- data_wr = 0, wr_en = 0, full = 0, word_cnt = 0;
- all edge-detect registers = 0.
REQ-030 rst mid-word or coincident with the final enter SHALL suppress the write.

Structure
REQ-031 Package prog_loader_pkg SHALL hold the state encoding and the CHUNKS/index-width helper functions.
REQ-032 One sub-module, edge_rise (1-bit registered rising-edge detector), SHALL be instantiated three times (enter, abort, set_addr).
REQ-033 Outputs SHALL be registered; next-state logic SHALL be a single combinational block.

Verification
Benches use SW_W=8, WORD_W=16, ADDR_W=4, START_ADDR=0.
REQ-034 Reset, then enter with switch=0xAB, then 0xCD: one wr_en pulse with addr_wr=0, data_wr=0xABCD; pointer then reads 1 and word_cnt reads 1.
REQ-035 Hold enter high for 10 cycles with switch=0x12: chunk_idx=1 and no wr_en.
REQ-036 Enter 0x11, then abort, then 0x22, 0x33: a single write of 0x2233 to addr 0; the 0x11 chunk is discarded.
REQ-037 set_addr with switch=0x0E, then write 0x0102 and 0x0304: writes to addr 14 and 15; full=1; a further enter produces no wr_en; set_addr with 0x03 clears full and the next write goes to addr 3.
REQ-038 Assert abort, set_addr and enter in the same cycle mid-word: abort wins, so chunk_idx=0, data_wr=0, the pointer is unchanged and there is no write.
REQ-039 Assert rst in the same cycle as the final enter edge: wr_en stays 0 and addr_wr = START_ADDR.
